lector_bcd_fecha: RTL and testbench
===================================

# lector_bcd_fecha

Frame reader that accepts a three-byte BCD date (day, month, year) read back from the RTC, validates each field, and converts it to the zero-based binary encodings used by the date counters. It is the reverse path of the counters' BCD decoders. On a clean frame it issues a one-cycle load pulse with the binary values. On a malformed frame it flags an error and leaves its outputs unchanged. It sits between the RTC read sequencer and the counters' parallel-load inputs.

## Interface
- No parameters; field limits are package constants.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sync  in  1  frame restart; clears the frame in progress
- in_valid  in  1  in_bcd holds a byte
- in_bcd  in  8  BCD byte: [7:4] tens, [3:0] units
- in_ready  out  1  block can accept a byte this cycle
- load  out  1  one-cycle pulse; binary outputs are new
- dia_bin  out  5  day − 1, range 0..30
- mes_bin  out  4  month − 1, range 0..11
- anio_bin  out  7  year, range 0..99
- err  out  1  one-cycle pulse; frame rejected
- busy  out  1  at least one byte of the current frame has been accepted

## Operation
- States:
  - S_DIA: reset state.
  - S_MES, S_ANIO: waiting for the next field.
  - S_LOAD: commit cycle.
- in_ready = 1 in S_DIA, S_MES and S_ANIO; 0 in S_LOAD.
- A byte transfers when in_valid & in_ready at a rising edge. Transitions on transfer: S_DIA→S_MES→S_ANIO→S_LOAD. S_LOAD→S_DIA is unconditional.
- Per byte:
  - Decode tens*10 + units.
  - The nibble is valid only if each digit ≤ 9.
  - Field ranges: day 01..31, month 01..12, year 00..99.
  - The stored value is day−1, month−1, year.
  - Day is not checked against month length.
- Any invalid byte sets a sticky frame error flag. The frame continues to S_LOAD regardless; it is not aborted early.
- In S_LOAD:
  - Error flag clear: dia_bin, mes_bin and anio_bin take the staged values, and load pulses.
  - Error flag set: err pulses and the outputs hold.
  - The error flag clears on leaving S_LOAD.
- sync = 1 at an edge:
  - Next state S_DIA; error flag and staged values are cleared.
  - The same-edge byte is dropped; sync has priority over in_valid.
  - In S_LOAD, sync suppresses load and err for that frame.
- busy = 1 in S_MES, S_ANIO and S_LOAD.
- Reset values: dia_bin 0, mes_bin 0, anio_bin 0, load 0, err 0, state S_DIA (so in_ready 1, busy 0). Reset asserted mid-frame discards the frame.

## Timing
- All outputs come from registers except in_ready and busy, which decode the state directly.
- Year byte accepted at edge N → state S_LOAD in cycle N..N+1.
- At edge N+1: binary outputs update, and load (or err) is high for exactly cycle N+1..N+2.
- in_ready is low for exactly one cycle per frame (cycle N..N+1). The first day byte of the next frame is accepted at edge N+2 at the earliest.
- Minimum frame: 4 cycles with in_valid held high.
- in_valid with in_ready low has no effect. The source must hold its byte until it transfers.
- Binary outputs are stable between load pulses.

## Structure
- Package fecha_pkg:
  - State enum.
  - Limits DIA_MAX=31, MES_MAX=12, ANIO_MAX=99.
  - Output widths 5/4/7.
- Sub-module bcd2bin_8, combinational:
  - Input: 8-bit BCD.
  - Outputs: 7-bit binary value and nibble_ok.
  - One instance on in_bcd; range checks are done in the parent, selected by state.
- Staging registers hold day and month while the frame is in progress. Year feeds the output register directly in S_LOAD from its own staging register.

## Test plan
- Reset low, then release: all outputs 0, in_ready 1, busy 0. Send 8'h15, 8'h08, 8'h24 back-to-back → load one cycle after the year byte; dia_bin 14, mes_bin 7, anio_bin 24, err 0.
- Month boundaries:
  - Frame 31/12/99 → 30, 11, 99.
  - Frame 01/01/00 → 0, 0, 0.
  - Frame with month 8'h13 → err pulse, no load, outputs keep the previous frame's values.
- Invalid nibble: day 8'h1A or year 8'h9F → err after the year byte; next valid frame loads normally (error flag does not persist).
- sync: assert with in_valid on the month byte → byte dropped, busy 0; full new frame 8'h02, 8'h02, 8'h20 → 1, 1, 20. Assert sync in S_LOAD → neither load nor err.
- Flow control:
  - Gapped in_valid (idle cycles between bytes) gives the same result as back-to-back.
  - in_valid held during the S_LOAD cycle does not transfer its byte, which is accepted on the following cycle as the next frame's day.
  - Async reset asserted mid-frame: state S_DIA immediately, outputs 0.

Source files
------------

// File: rtl/fecha_pkg.sv
// Shared constants for the BCD date frame reader: state codes, field limits and
// the widths of the zero-based binary date encodings.
package fecha_pkg;

    localparam int DIA_W  = 5;
    localparam int MES_W  = 4;
    localparam int ANIO_W = 7;

    localparam logic [6:0] DIA_MAX  = 7'd31;
    localparam logic [6:0] MES_MAX  = 7'd12;
    localparam logic [6:0] ANIO_MAX = 7'd99;

    // Frame position; S_LOAD is the single commit cycle after the year byte.
    localparam logic [1:0] S_DIA  = 2'd0;
    localparam logic [1:0] S_MES  = 2'd1;
    localparam logic [1:0] S_ANIO = 2'd2;
    localparam logic [1:0] S_LOAD = 2'd3;

endpackage

// File: rtl/bcd2bin_8.sv
// Two-digit BCD to binary converter. The value is meaningless when nibble_ok is
// low; the caller decides what to do with a bad digit.
module bcd2bin_8 (
    input  logic [7:0] bcd,
    output logic [6:0] bin,
    output logic       nibble_ok
);

    logic [6:0] tens;
    logic [6:0] units;

    assign tens      = {3'b000, bcd[7:4]};
    assign units     = {3'b000, bcd[3:0]};
    assign bin       = tens * 7'd10 + units;
    assign nibble_ok = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);

endmodule

// File: rtl/lector_bcd_fecha.sv
// Reads a day/month/year BCD frame from the RTC, validates every field and
// hands zero-based binary values to the date counters with a one-cycle load.
module lector_bcd_fecha
    import fecha_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              in_valid,
    input  logic [7:0]        in_bcd,
    output logic              in_ready,
    output logic              load,
    output logic [DIA_W-1:0]  dia_bin,
    output logic [MES_W-1:0]  mes_bin,
    output logic [ANIO_W-1:0] anio_bin,
    output logic              err,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              err_flag_q, err_flag_d;
    logic [DIA_W-1:0]  dia_stg_q, dia_stg_d;
    logic [MES_W-1:0]  mes_stg_q, mes_stg_d;
    logic [ANIO_W-1:0] anio_stg_q, anio_stg_d;
    logic [DIA_W-1:0]  dia_bin_q, dia_bin_d;
    logic [MES_W-1:0]  mes_bin_q, mes_bin_d;
    logic [ANIO_W-1:0] anio_bin_q, anio_bin_d;
    logic              load_q, load_d;
    logic              err_q, err_d;

    logic [6:0] bin;
    logic       nibble_ok;
    logic       field_ok;
    logic       xfer;

    bcd2bin_8 u_bcd2bin (
        .bcd       (in_bcd),
        .bin       (bin),
        .nibble_ok (nibble_ok)
    );

    assign in_ready = (state_q != S_LOAD);
    assign busy     = (state_q != S_DIA);
    assign xfer     = in_valid && in_ready;

    // One converter is shared; the range applied depends on which field is expected.
    always_comb begin
        field_ok = 1'b0;
        case (state_q)
            S_DIA:   field_ok = nibble_ok && (bin >= 7'd1) && (bin <= DIA_MAX);
            S_MES:   field_ok = nibble_ok && (bin >= 7'd1) && (bin <= MES_MAX);
            S_ANIO:  field_ok = nibble_ok && (bin <= ANIO_MAX);
            default: field_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        err_flag_d = err_flag_q;
        dia_stg_d  = dia_stg_q;
        mes_stg_d  = mes_stg_q;
        anio_stg_d = anio_stg_q;
        dia_bin_d  = dia_bin_q;
        mes_bin_d  = mes_bin_q;
        anio_bin_d = anio_bin_q;
        load_d     = 1'b0;
        err_d      = 1'b0;
        if (sync) begin
            state_d    = S_DIA;
            err_flag_d = 1'b0;
            dia_stg_d  = '0;
            mes_stg_d  = '0;
            anio_stg_d = '0;
        end else begin
            case (state_q)
                S_DIA: if (xfer) begin
                    dia_stg_d  = DIA_W'(bin - 7'd1);
                    err_flag_d = err_flag_q | ~field_ok;
                    state_d    = S_MES;
                end
                S_MES: if (xfer) begin
                    mes_stg_d  = MES_W'(bin - 7'd1);
                    err_flag_d = err_flag_q | ~field_ok;
                    state_d    = S_ANIO;
                end
                S_ANIO: if (xfer) begin
                    anio_stg_d = bin;
                    err_flag_d = err_flag_q | ~field_ok;
                    state_d    = S_LOAD;
                end
                default: begin
                    // A rejected frame leaves the counters' view of the date untouched.
                    if (err_flag_q) begin
                        err_d = 1'b1;
                    end else begin
                        dia_bin_d  = dia_stg_q;
                        mes_bin_d  = mes_stg_q;
                        anio_bin_d = anio_stg_q;
                        load_d     = 1'b1;
                    end
                    err_flag_d = 1'b0;
                    state_d    = S_DIA;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_DIA;
            err_flag_q <= 1'b0;
            dia_stg_q  <= '0;
            mes_stg_q  <= '0;
            anio_stg_q <= '0;
            dia_bin_q  <= '0;
            mes_bin_q  <= '0;
            anio_bin_q <= '0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_flag_q <= err_flag_d;
            dia_stg_q  <= dia_stg_d;
            mes_stg_q  <= mes_stg_d;
            anio_stg_q <= anio_stg_d;
            dia_bin_q  <= dia_bin_d;
            mes_bin_q  <= mes_bin_d;
            anio_bin_q <= anio_bin_d;
            load_q     <= load_d;
            err_q      <= err_d;
        end
    end

    assign dia_bin  = dia_bin_q;
    assign mes_bin  = mes_bin_q;
    assign anio_bin = anio_bin_q;
    assign load     = load_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lector_bcd_fecha.sv
// Directed and randomized frames for the BCD date reader, checked against a
// decimal-arithmetic model of the date fields.
module tb_lector_bcd_fecha;

    logic       clk;
    logic       reset;
    logic       sync;
    logic       in_valid;
    logic [7:0] in_bcd;
    logic       in_ready;
    logic       load;
    logic [4:0] dia_bin;
    logic [3:0] mes_bin;
    logic [6:0] anio_bin;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int m_dia  = 0;
    int m_mes  = 0;
    int m_anio = 0;

    lector_bcd_fecha dut (
        .clk      (clk),
        .reset    (reset),
        .sync     (sync),
        .in_valid (in_valid),
        .in_bcd   (in_bcd),
        .in_ready (in_ready),
        .load     (load),
        .dia_bin  (dia_bin),
        .mes_bin  (mes_bin),
        .anio_bin (anio_bin),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal view of a BCD field: each digit 0..9 and the value inside [lo,hi].
    function automatic bit field(input logic [7:0] b, input int lo, input int hi, output int v);
        int t;
        int u;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = t * 10 + u;
        return (t <= 9) && (u <= 9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Offers a byte and returns #1 after the edge that transferred it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = b;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called while in the commit cycle; checks the result one edge later.
    task automatic check_commit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        int  vd, vm, vy;
        bit  okd, okm, oky, ok;
        okd = field(d, 1, 31, vd);
        okm = field(m, 1, 12, vm);
        oky = field(y, 0, 99, vy);
        ok  = okd && okm && oky;
        check("commit_in_ready", in_ready, 0);
        check("commit_busy", busy, 1);
        @(posedge clk);
        #1;
        if (ok) begin
            m_dia  = vd - 1;
            m_mes  = vm - 1;
            m_anio = vy;
        end
        check("load", load, ok);
        check("err", err, !ok);
        check("dia_bin", dia_bin, m_dia);
        check("mes_bin", mes_bin, m_mes);
        check("anio_bin", anio_bin, m_anio);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                              input int gap);
        send_byte(d);
        idle(gap);
        send_byte(m);
        idle(gap);
        send_byte(y);
        check_commit(d, m, y);
    endtask

    initial begin
        logic [7:0] d, m, y;
        reset    = 1'b0;
        sync     = 1'b0;
        in_valid = 1'b0;
        in_bcd   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_dia", dia_bin, 0);
        check("rst_mes", mes_bin, 0);
        check("rst_anio", anio_bin, 0);
        check("rst_load", load, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);

        send_frame(8'h15, 8'h08, 8'h24, 0);
        @(posedge clk);
        #1;
        check("load_width", load, 0);

        send_frame(8'h31, 8'h12, 8'h99, 0);
        send_frame(8'h01, 8'h01, 8'h00, 0);
        send_frame(8'h20, 8'h13, 8'h30, 0);
        send_frame(8'h1A, 8'h05, 8'h10, 0);
        send_frame(8'h09, 8'h09, 8'h09, 0);
        send_frame(8'h10, 8'h03, 8'h9F, 1);
        send_frame(8'h00, 8'h03, 8'h05, 0);
        send_frame(8'h32, 8'h03, 8'h05, 0);
        send_frame(8'h28, 8'h02, 8'h21, 0);

        // sync on the month byte drops it and restarts the frame
        send_byte(8'h05);
        @(negedge clk);
        sync     = 1'b1;
        in_valid = 1'b1;
        in_bcd   = 8'h03;
        @(posedge clk);
        #1;
        sync     = 1'b0;
        in_valid = 1'b0;
        check("sync_busy", busy, 0);
        check("sync_in_ready", in_ready, 1);
        send_frame(8'h02, 8'h02, 8'h20, 0);

        // sync in the commit cycle suppresses both pulses
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h11);
        @(negedge clk);
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        check("sync_load_load", load, 0);
        check("sync_load_err", err, 0);
        check("sync_load_dia", dia_bin, m_dia);
        check("sync_load_busy", busy, 0);

        // gapped stream matches back-to-back
        send_frame(8'h15, 8'h08, 8'h24, 3);

        // byte held through the commit cycle becomes the next frame's day
        send_byte(8'h07);
        send_byte(8'h06);
        send_byte(8'h05);
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 8'h10;
        check_commit(8'h07, 8'h06, 8'h05);
        check("held_not_taken", busy, 0);
        @(posedge clk);
        #1;
        check("held_taken", busy, 1);
        in_valid = 1'b0;
        send_byte(8'h04);
        send_byte(8'h03);
        check_commit(8'h10, 8'h04, 8'h03);

        // async reset mid-frame
        send_byte(8'h12);
        send_byte(8'h12);
        #2;
        reset = 1'b0;
        #1;
        m_dia  = 0;
        m_mes  = 0;
        m_anio = 0;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_dia", dia_bin, 0);
        check("arst_mes", mes_bin, 0);
        check("arst_anio", anio_bin, 0);
        @(negedge clk);
        reset = 1'b1;
        send_frame(8'h25, 8'h11, 8'h42, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom);
                m = 8'($urandom);
                y = 8'($urandom);
            end else begin
                d = to_bcd(int'($urandom_range(1, 31)));
                m = to_bcd(int'($urandom_range(1, 12)));
                y = to_bcd(int'($urandom_range(0, 99)));
            end
            send_frame(d, m, y, int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
